io_lcd_driver: RTL and testbench
================================

# io_lcd_driver

Four-digit multiplexed seven-segment display driver for the IO shield. It takes four 4-bit hex nibbles with per-digit enables and time-multiplexes them onto the shared active-low anode-select and segment buses. It sits between the user datapath and the top-level `IO_AN`/`IO_SEG` pins.

## Interface

- Clocking: one clock; reset is asynchronous and active-high.

Parameters:
- `CYCLES_PER_DIGIT`, default 100000: clock cycles each digit stays selected (1 ms at 100 MHz).
  - Legal range ≥ 2.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-high reset.
- `i_digit1` in 4: hex value for digit 1, the rightmost and least-significant digit.
- `i_show_digit1` in 1: 1 = display digit 1; 0 = blank it.
- `i_digit2`, `i_show_digit2`: same pair for digit 2.
- `i_digit3`, `i_show_digit3`: same pair for digit 3.
- `i_digit4`, `i_show_digit4`: same pair for digit 4, the leftmost digit.
- `o_select` out 4: anode select, active-low one-hot; bit n-1 drives digit n.
- `o_segment` out 8: segments, active-low.
  - bit0 = a, bit1 = b, bit2 = c, bit3 = d, bit4 = e, bit5 = f, bit6 = g, bit7 = dp.

## Operation

- Free-running cycle counter runs 0 … `CYCLES_PER_DIGIT`-1, then wraps to 0.
  - On wrap, the 2-bit digit index advances: 0→1→2→3→0.
- Index k selects `i_digit(k+1)` and `i_show_digit(k+1)`.
- Shown digit:
  - `o_select` = ~(1<<k).
  - `o_segment` = hex decode of the nibble.
  - dp is always off, so bit7 = 1.
- Blanked digit (show = 0):
  - `o_select` = 4'hF.
  - `o_segment` = 8'hFF.
- Hex decode (active-low, dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- At most one `o_select` bit is low at any time.
- Inputs are sampled continuously, not latched per scan slot. A nibble change during its slot appears on the next clock.

## Timing

- Reset (asynchronous, active-high):
  - counter = 0, index = 0.
  - `o_select` = 4'hF, `o_segment` = 8'hFF.
- Both outputs are registered: they reflect the index and inputs sampled at the previous rising edge (1-cycle latency).
- First rising edge after reset release:
  - outputs show digit 1, e.g. `o_select` = 4'b1110.
- Each digit is held for exactly `CYCLES_PER_DIGIT` cycles.
  - Full frame = 4 × `CYCLES_PER_DIGIT` cycles.
- Index change and output update happen on the same edge. There is no ghosting interval; none is required.
- Reset mid-scan: outputs go to the reset values immediately (asynchronously). The scan restarts at digit 1.
- Toggling `i_show_digitN` during slot N-1 blanks or unblanks that slot on the next edge. The scan cadence is unaffected.

## Structure

- Shared package `io_lcd_pkg`:
  - segment-bit index constants (SEG_A … SEG_DP);
  - `SEG_BLANK` = 8'hFF;
  - `SEL_NONE` = 4'hF;
  - the 16-entry active-low hex pattern constants.
- One combinational sub-module `hex_to_seg7`: 4-bit nibble in → 7-bit active-low a–g out.
- Top of the block holds:
  - the counter and index registers;
  - the 4:1 input mux;
  - blank logic;
  - the output registers.

## Test plan

All scenarios use `CYCLES_PER_DIGIT` = 4.

1. Reset:
   - Hold `rst` = 1 → `o_select` = F, `o_segment` = FF.
   - Assert `rst` asynchronously mid-slot → outputs return to F/FF before the next edge.
2. Scan order:
   - digits = 1, 2, 3, 4, all shown.
   - → after release, 4 cycles each:
     - E/F9
     - D/A4
     - B/B0
     - 7/99
   - → then wraps to E/F9.
3. Full decode:
   - Sweep `i_digit1` over 0–F while in slot 0.
   - → `o_segment` matches the table, one cycle after each change; `o_select` stays E.
4. Blanking:
   - `i_show_digit3` = 0 → during slot 2, `o_select` = F and `o_segment` = FF.
   - Other slots are unchanged and the frame length stays 16 cycles.
5. Counter source:
   - Drive the digits from a 16-bit counter held at 16'hA5C3.
   - → slots show 3 (B0), C (C6), 5 (92), A (88).
6. One-hot check:
   - Random inputs and resets over 10k cycles.
   - → `o_select` is never anything other than F, E, D, B or 7.

Source files
------------

// File: rtl/io_lcd_pkg.sv
// rtl/io_lcd_pkg.sv - shared constants for the seven-segment display driver
package io_lcd_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] SEL_NONE  = 4'hF;

  // Active-low patterns with dp off; entry n is the glyph for nibble n.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low a..g segments
module hex_to_seg7
  import io_lcd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  logic [7:0] pattern;

  assign pattern = HEX_SEG[nibble];
  assign seg     = pattern[SEG_G:SEG_A];

endmodule

// File: rtl/io_lcd_driver.sv
// rtl/io_lcd_driver.sv - four-digit multiplexed seven-segment driver
module io_lcd_driver
  import io_lcd_pkg::*;
#(
  parameter int CYCLES_PER_DIGIT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_digit1,
  input  logic       i_show_digit1,
  input  logic [3:0] i_digit2,
  input  logic       i_show_digit2,
  input  logic [3:0] i_digit3,
  input  logic       i_show_digit3,
  input  logic [3:0] i_digit4,
  input  logic       i_show_digit4,
  output logic [3:0] o_select,
  output logic [7:0] o_segment
);

  localparam int CW = (CYCLES_PER_DIGIT > 2) ? $clog2(CYCLES_PER_DIGIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES_PER_DIGIT - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic          show;
  logic [6:0]    dec;
  logic [3:0]    sel_next;
  logic [7:0]    seg_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nib  = i_digit1;
    show = i_show_digit1;
    case (idx)
      2'd1: begin nib = i_digit2; show = i_show_digit2; end
      2'd2: begin nib = i_digit3; show = i_show_digit3; end
      2'd3: begin nib = i_digit4; show = i_show_digit4; end
      default: begin nib = i_digit1; show = i_show_digit1; end
    endcase
  end

  hex_to_seg7 u_dec (
    .nibble (nib),
    .seg    (dec)
  );

  // Blanked slots release the anode as well, so the decimal point never lights.
  always_comb begin
    sel_next = SEL_NONE;
    seg_next = SEG_BLANK;
    if (show) begin
      sel_next              = ~(4'b0001 << idx);
      seg_next[SEG_G:SEG_A] = dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_select  <= SEL_NONE;
      o_segment <= SEG_BLANK;
    end else begin
      o_select  <= sel_next;
      o_segment <= seg_next;
    end
  end

endmodule

// File: tb/tb_io_lcd_driver.sv
// tb/tb_io_lcd_driver.sv - self-checking bench for io_lcd_driver
module tb_io_lcd_driver;

  localparam int CPD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d1 = 4'h0, d2 = 4'h0, d3 = 4'h0, d4 = 4'h0;
  logic       s1 = 1'b1, s2 = 1'b1, s3 = 1'b1, s4 = 1'b1;
  logic [3:0] o_select;
  logic [7:0] o_segment;

  int vectors = 0;
  int miscompares = 0;

  io_lcd_driver #(.CYCLES_PER_DIGIT(CPD)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_digit1      (d1),
    .i_show_digit1 (s1),
    .i_digit2      (d2),
    .i_show_digit2 (s2),
    .i_digit3      (d3),
    .i_show_digit3 (s3),
    .i_digit4      (d4),
    .i_show_digit4 (s4),
    .o_select      (o_select),
    .o_segment     (o_segment)
  );

  always #5 clk = ~clk;

  // Reference model: slot follows from edges elapsed since reset.
  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int         m_edges;
  int         m_slot;
  logic [3:0] m_sel;
  logic [7:0] m_seg;
  logic [3:0] m_nib;
  logic       m_show;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges = 0;
      m_sel   = 4'hF;
      m_seg   = 8'hFF;
    end else begin
      m_slot = (m_edges / CPD) % 4;
      m_nib  = (m_slot == 0) ? d1 : (m_slot == 1) ? d2 : (m_slot == 2) ? d3 : d4;
      m_show = (m_slot == 0) ? s1 : (m_slot == 1) ? s2 : (m_slot == 2) ? s3 : s4;
      if (m_show) begin
        m_sel = 4'hF;
        m_sel[m_slot] = 1'b0;
        m_seg = glyph[m_nib];
      end else begin
        m_sel = 4'hF;
        m_seg = 8'hFF;
      end
      m_edges = m_edges + 1;
    end
  end

  task automatic chk(input string name, input logic [3:0] es, input logic [7:0] eg);
    vectors++;
    if (o_select !== es || o_segment !== eg) begin
      miscompares++;
      $display("FAIL %s: got sel=%h seg=%h, want sel=%h seg=%h", name, o_select, o_segment, es, eg);
    end
  endtask

  task automatic set_digits(input logic [15:0] v, input logic [3:0] shows);
    {d4, d3, d2, d1} = v;
    {s4, s3, s2, s1} = shows;
  endtask

  // Reset held across one posedge, released on a negedge.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] nib;
    logic [7:0] seg;
  } dec_vec_t;

  dec_vec_t tbl [16];

  logic [3:0] scan_sel [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] scan_seg [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
  logic [7:0] cnt_seg  [4] = '{8'hB0, 8'hC6, 8'h92, 8'h88};

  initial begin
    tbl[0]  = '{4'h0, 8'hC0}; tbl[1]  = '{4'h1, 8'hF9};
    tbl[2]  = '{4'h2, 8'hA4}; tbl[3]  = '{4'h3, 8'hB0};
    tbl[4]  = '{4'h4, 8'h99}; tbl[5]  = '{4'h5, 8'h92};
    tbl[6]  = '{4'h6, 8'h82}; tbl[7]  = '{4'h7, 8'hF8};
    tbl[8]  = '{4'h8, 8'h80}; tbl[9]  = '{4'h9, 8'h90};
    tbl[10] = '{4'hA, 8'h88}; tbl[11] = '{4'hB, 8'h83};
    tbl[12] = '{4'hC, 8'hC6}; tbl[13] = '{4'hD, 8'hA1};
    tbl[14] = '{4'hE, 8'h86}; tbl[15] = '{4'hF, 8'h8E};

    // Reset held
    set_digits(16'h4321, 4'hF);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_hold", 4'hF, 8'hFF);

    // Scan order, including wrap back to digit 1
    rst = 1'b0;
    for (int e = 0; e < 4 * 4 * CPD / 4 + 1; e++) begin
      @(negedge clk);
      chk($sformatf("scan_e%0d", e), scan_sel[(e / CPD) % 4], scan_seg[(e / CPD) % 4]);
    end

    // Asynchronous reset mid-slot takes effect before the next edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", 4'hF, 8'hFF);
    @(negedge clk);
    rst = 1'b0;

    // Full decode sweep in slot 0, one nibble change per cycle
    for (int i = 0; i < 16; i++) begin
      if (i % CPD == 0) do_reset();
      d1 = tbl[i].nib;
      @(negedge clk);
      chk($sformatf("decode_%h", tbl[i].nib), 4'hE, tbl[i].seg);
    end

    // Blanking digit 3; frame length stays 4*CPD
    set_digits(16'h4321, 4'b1011);
    do_reset();
    for (int e = 0; e < 4 * CPD + 1; e++) begin
      @(negedge clk);
      if ((e / CPD) % 4 == 2)
        chk($sformatf("blank_e%0d", e), 4'hF, 8'hFF);
      else
        chk($sformatf("blank_e%0d", e), scan_sel[(e / CPD) % 4], scan_seg[(e / CPD) % 4]);
    end

    // Digits from a counter value
    set_digits(16'hA5C3, 4'hF);
    do_reset();
    for (int e = 0; e < 4 * CPD; e++) begin
      @(negedge clk);
      chk($sformatf("cnt_e%0d", e), scan_sel[e / CPD], cnt_seg[e / CPD]);
    end

    // Randomized run against the model with occasional resets
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      chk("random_model", m_sel, m_seg);
      vectors++;
      if (!(o_select inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) begin
        miscompares++;
        $display("FAIL one_hot: got sel=%h, want one of F/E/D/B/7", o_select);
      end
      d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom); d4 = 4'($urandom);
      {s4, s3, s2, s1} = 4'($urandom | $urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1 chk("random_async_reset", 4'hF, 8'hFF);
      end else begin
        rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
